// File: rtl/param_mem_bist.sv
// March-test BIST initiator for a single-port memory with one-cycle registered read data.
// Runs W(BG) up, R(BG)/W(~BG) up, R(~BG)/W(BG) down, R(BG) up, and reports the first failure.
module param_mem_bist #(
  parameter int                SIZE    = 256,
  parameter int                WIDTH   = 8,
  parameter int                ADDR_W  = 8,
  parameter logic [WIDTH-1:0]  PATTERN = 'h55,
  parameter int                ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [WIDTH-1:0]  fail_data,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic [2:0] {
    IDLE, P0_W_UP, P1_RW_UP, P2_RW_DOWN, P3_R_UP, DRAIN, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_phase_q, wr_phase_d;
  logic                chk_valid_q, chk_valid_d;
  logic [WIDTH-1:0]    chk_exp_q, chk_exp_d;
  logic [ADDR_W-1:0]   chk_addr_q, chk_addr_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [WIDTH-1:0]    fail_data_q, fail_data_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_phase_q  <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_exp_q   <= '0;
      chk_addr_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_phase_q  <= wr_phase_d;
      chk_valid_q <= chk_valid_d;
      chk_exp_q   <= chk_exp_d;
      chk_addr_q  <= chk_addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_phase_d  = wr_phase_q;
    chk_valid_d = 1'b0;
    chk_exp_d   = chk_exp_q;
    chk_addr_d  = chk_addr_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    // Read data issued last cycle is on mem_rdata now; the pipeline holds what it should be.
    mismatch = chk_valid_q && (mem_rdata != chk_exp_q);
    if (mismatch) begin
      if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = chk_addr_q;
        fail_data_d = mem_rdata;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = P0_W_UP;
          addr_d      = '0;
          wr_phase_d  = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          err_d       = '0;
        end
      end
      P0_W_UP: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = PATTERN;
        if (addr_q == LAST_ADDR) begin
          state_d = P1_RW_UP;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      P1_RW_UP: begin
        mem_addr = addr_q;
        if (!wr_phase_q) begin
          chk_valid_d = 1'b1;
          chk_exp_d   = PATTERN;
          chk_addr_d  = addr_q;
          wr_phase_d  = 1'b1;
        end else begin
          mem_we     = 1'b1;
          mem_wdata  = ~PATTERN;
          wr_phase_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            state_d = P2_RW_DOWN;
            addr_d  = LAST_ADDR;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      P2_RW_DOWN: begin
        mem_addr = addr_q;
        if (!wr_phase_q) begin
          chk_valid_d = 1'b1;
          chk_exp_d   = ~PATTERN;
          chk_addr_d  = addr_q;
          wr_phase_d  = 1'b1;
        end else begin
          mem_we     = 1'b1;
          mem_wdata  = PATTERN;
          wr_phase_d = 1'b0;
          // Stop at address 0 rather than letting the down-counter wrap.
          if (addr_q == '0) begin
            state_d = P3_R_UP;
          end else begin
            addr_d = addr_q - ADDR_W'(1);
          end
        end
      end
      P3_R_UP: begin
        mem_addr    = addr_q;
        chk_valid_d = 1'b1;
        chk_exp_d   = PATTERN;
        chk_addr_d  = addr_q;
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_param_mem_bist.sv
// Bench for param_mem_bist: SIZE=16/ERR_W=4 instance with an injectable faulty memory,
// plus a SIZE=4 instance whose port trace is compared cycle by cycle.
module tb_param_mem_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;

  logic       mem_we_a, busy_a, done_a, fail_a;
  logic [7:0] mem_addr_a, mem_wdata_a, rdata_a, fail_addr_a, fail_data_a;
  logic [3:0] err_a;

  logic       mem_we_b, busy_b, done_b, fail_b;
  logic [7:0] mem_addr_b, mem_wdata_b, rdata_b, fail_addr_b, fail_data_b;
  logic [7:0] err_b;

  param_mem_bist #(.SIZE(16), .WIDTH(8), .ADDR_W(8), .PATTERN(8'h55), .ERR_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(rdata_a),
    .busy(busy_a), .done(done_a), .fail(fail_a), .fail_addr(fail_addr_a),
    .fail_data(fail_data_a), .err_count(err_a)
  );

  param_mem_bist #(.SIZE(4), .WIDTH(8), .ADDR_W(8), .PATTERN(8'h55), .ERR_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(rdata_b),
    .busy(busy_b), .done(done_b), .fail(fail_b), .fail_addr(fail_addr_b),
    .fail_data(fail_data_b), .err_count(err_b)
  );

  // Fault modes: 0 none, 1 bit0 stuck-at-0 at fault_addr, 2 bit7 stuck-at-1 everywhere.
  int fault_mode = 0;
  int fault_addr = 0;

  function automatic logic [7:0] faulty(input int mode, input int fa, input logic [7:0] a,
                                        input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (mode == 1 && a == fa[7:0]) r[0] = 1'b0;
    if (mode == 2) r[7] = 1'b1;
    return r;
  endfunction

  logic [7:0] mem_a [16];
  logic [7:0] mem_b [4];
  int oor_a = 0;
  int oor_b = 0;

  // Single-port memories: data_out only updates on a read.
  always @(posedge clk) begin
    if (mem_we_a) mem_a[mem_addr_a[3:0]] <= faulty(fault_mode, fault_addr, mem_addr_a, mem_wdata_a);
    else          rdata_a <= mem_a[mem_addr_a[3:0]];
    if (mem_we_b) mem_b[mem_addr_b[1:0]] <= mem_wdata_b;
    else          rdata_b <= mem_b[mem_addr_b[1:0]];
    if (busy_a && mem_addr_a >= 8'd16) oor_a <= oor_a + 1;
    if (busy_b && mem_addr_b >= 8'd4)  oor_b <= oor_b + 1;
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in run cycle 1; returns the cycle in which done rose (0 on timeout).
  task automatic wait_done_a(output int done_cyc, output int busy_bad);
    int cyc;
    cyc = 1;
    done_cyc = 0;
    busy_bad = 0;
    while (cyc <= 300 && !done_a) begin
      if (!busy_a) busy_bad++;
      tick();
      cyc++;
    end
    if (done_a) done_cyc = cyc;
  endtask

  typedef struct {
    int         mode;
    int         faddr;
    logic       exp_fail;
    logic [7:0] exp_faddr;
    logic [7:0] exp_fdata;
    logic [3:0] exp_err;
    logic [7:0] exp_word_other;
    logic [7:0] exp_word_fault;
  } vec_t;

  vec_t vecs [5];

  int exp_addr_b [24] = '{0,1,2,3, 0,0,1,1,2,2,3,3, 3,3,2,2,1,1,0,0, 0,1,2,3};
  int exp_we_b   [24] = '{1,1,1,1, 0,1,0,1,0,1,0,1, 0,1,0,1,0,1,0,1, 0,0,0,0};
  int exp_wd_b   [24] = '{'h55,'h55,'h55,'h55,
                          0,'hAA,0,'hAA,0,'hAA,0,'hAA,
                          0,'h55,0,'h55,0,'h55,0,'h55,
                          0,0,0,0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, bb, bad;

    vecs[0] = '{0, 0,  1'b0, 8'h00, 8'h00, 4'd0,  8'h55, 8'h55};
    vecs[1] = '{1, 5,  1'b1, 8'h05, 8'h54, 4'd2,  8'h55, 8'h54};
    vecs[2] = '{2, 0,  1'b1, 8'h00, 8'hD5, 4'd15, 8'hD5, 8'hD5};
    vecs[3] = '{1, 15, 1'b1, 8'h0F, 8'h54, 4'd2,  8'h55, 8'h54};
    vecs[4] = '{1, 0,  1'b1, 8'h00, 8'h54, 4'd2,  8'h55, 8'h54};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) tick();
    check("reset_port_a", {mem_we_a, mem_addr_a, mem_wdata_a, busy_a, done_a}, 0);
    check("reset_stat_a", {fail_a, fail_addr_a, fail_data_a, err_a}, 0);
    check("reset_port_b", {mem_we_b, mem_addr_b, mem_wdata_b, busy_b, done_b}, 0);
    check("reset_stat_b", {fail_b, fail_addr_b, fail_data_b, err_b}, 0);
    rst = 1'b0;

    // Each vector starts in cycle 0: after reset for the first, in the first DONE cycle after.
    for (int i = 0; i < 5; i++) begin
      fault_mode = vecs[i].mode;
      fault_addr = vecs[i].faddr;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check("first_cmd", {mem_we_a, mem_addr_a, mem_wdata_a}, {1'b1, 8'h00, 8'h55});
      wait_done_a(dc, bb);
      check("done_cycle", dc, 98);
      check("busy_window", bb, 0);
      check("busy_at_done", busy_a, 0);
      check("fail", fail_a, vecs[i].exp_fail);
      check("fail_addr", fail_addr_a, vecs[i].exp_faddr);
      check("fail_data", fail_data_a, vecs[i].exp_fdata);
      check("err_count", err_a, vecs[i].exp_err);
      bad = 0;
      for (int w = 0; w < 16; w++)
        if (mem_a[w] !== ((w == vecs[i].faddr) ? vecs[i].exp_word_fault : vecs[i].exp_word_other))
          bad++;
      check("final_mem", bad, 0);
      $display("vec %0d mode=%0d faddr=%0d done@%0d fail=%0b fail_addr=%0d fail_data=%02h err=%0d",
               i, vecs[i].mode, vecs[i].faddr, dc, fail_a, fail_addr_a, fail_data_a, err_a);
    end

    // Reset in cycle 20 of a run, restart in cycle 22.
    fault_mode = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    check("midrst_port", {mem_we_a, mem_addr_a, mem_wdata_a, busy_a, done_a}, 0);
    check("midrst_stat", {fail_a, fail_addr_a, fail_data_a, err_a}, 0);
    rst = 1'b0;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done_a(dc, bb);
    check("midrst_done_cycle", dc, 98);
    check("midrst_result", {fail_a, err_a}, 0);
    $display("mid-run reset: restart done@%0d (relative to cycle 22) fail=%0b err=%0d", dc, fail_a, err_a);

    // start held high for a whole run, then still high in the first DONE cycle.
    fault_mode = 1;
    fault_addr = 5;
    start_a = 1'b1;
    tick();
    wait_done_a(dc, bb);
    check("held_done_cycle", dc, 98);
    check("held_busy_window", bb, 0);
    check("held_result", {fail_a, fail_addr_a, fail_data_a, err_a}, {1'b1, 8'h05, 8'h54, 4'd2});
    fault_mode = 0;
    tick();
    check("b2b_restart", {busy_a, done_a}, 2'b10);
    check("b2b_cleared", {fail_a, fail_addr_a, fail_data_a, err_a}, 0);
    start_a = 1'b0;
    wait_done_a(dc, bb);
    check("b2b_done_cycle", dc, 98);
    check("b2b_result", {fail_a, err_a}, 0);
    $display("held start: second run done@%0d fail=%0b err=%0d", dc, fail_a, err_a);

    // SIZE=4 port trace.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 24; k++) begin
      check($sformatf("trace_addr[%0d]", k), mem_addr_b, exp_addr_b[k]);
      check($sformatf("trace_we[%0d]", k), mem_we_b, exp_we_b[k]);
      check($sformatf("trace_wdata[%0d]", k), mem_wdata_b, exp_wd_b[k]);
      tick();
    end
    check("trace_drain", {busy_b, done_b, mem_we_b}, 3'b100);
    tick();
    check("trace_done", {busy_b, done_b, fail_b, err_b}, {3'b010, 8'd0});
    bad = 0;
    for (int w = 0; w < 4; w++) if (mem_b[w] !== 8'h55) bad++;
    check("trace_final_mem", bad, 0);
    check("addr_range", oor_a + oor_b, 0);
    $display("SIZE=4 trace: 24 command cycles, done=%0b fail=%0b err=%0d", done_b, fail_b, err_b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/param_mem_bist.md
# param_mem_bist

Built-in self-test initiator for the single-port parameterised memory (one `write_enable`, one address, registered read data with one-cycle latency). On `start` it drives the memory's write/address/data port through a four-phase march sequence, checks every read against the expected pattern, and reports pass/fail, the first failing address and data, and a saturating error count. It sits beside the memory and owns that memory's port for the duration of a test.

## Interface
- `SIZE`, 256, number of words tested (addresses 0..SIZE-1); 2 ≤ SIZE ≤ 2**ADDR_W
- `WIDTH`, 8, data word width
- `ADDR_W`, 8, address width
- `PATTERN`, 8'h55, background pattern BG (WIDTH bits); the inverse ~BG is the complement pattern
- `ERR_W`, 8, width of the error counter
- `clk` input 1: clock. Single clock domain.
- `rst` input 1: reset. Synchronous, active-high.
- `start` input 1: begin a test; sampled only in IDLE or DONE
- `mem_we` output 1: memory write enable (drives `write_enable`)
- `mem_addr` output ADDR_W: memory address
- `mem_wdata` output WIDTH: memory write data
- `mem_rdata` input WIDTH: memory read data (memory `data_out`)
- `busy` output 1: test in progress
- `done` output 1: level, test finished; held until the next `start` or `rst`
- `fail` output 1: sticky, at least one mismatch in the current or last test
- `fail_addr` output ADDR_W: address of the first mismatch
- `fail_data` output WIDTH: `mem_rdata` value at the first mismatch
- `err_count` output ERR_W: mismatch count, saturates at 2**ERR_W-1

## Operation
- States: IDLE, P0_W_UP, P1_RW_UP, P2_RW_DOWN, P3_R_UP, DRAIN, DONE.
- IDLE or DONE with `start`=1: clear `fail`, `fail_addr`, `fail_data`, `err_count` and `done`; set address to 0; go to P0.
- P0: write BG to addresses 0..SIZE-1 ascending, one write per cycle.
- P1: for each address 0..SIZE-1 ascending, read cycle (expect BG), then write cycle (~BG). Two cycles per address.
- P2: for each address SIZE-1..0 descending, read cycle (expect ~BG), then write cycle (BG). The descending counter terminates at 0 without wrapping.
- P3: read addresses 0..SIZE-1 ascending (expect BG), one read per cycle.
- DRAIN: one cycle to compare the last P3 read, then DONE.
- Read command: `mem_we`=0, `mem_wdata`=0. Write command: `mem_we`=1.
- Compare: a read presented during cycle n is compared against its expected value during cycle n+1. Carry the expected value and address in a one-stage check pipeline with a valid flag. The P1/P2 write to the same address happens in that same cycle n+1, which is legal because the memory does not update `data_out` on a write.
- Mismatch: increment `err_count`, saturating. On the first mismatch only, set `fail` and latch `fail_addr` and `fail_data`.
- `start` while busy: ignored.
- `rst`, including mid-test: next state IDLE. All outputs are 0 after the reset edge, which releases the memory port (`mem_we`=0) immediately.
- In IDLE and DONE: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
- Reset values: `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `fail`, `fail_addr`, `fail_data`, `err_count` are all 0.
- `start` is sampled at the end of cycle 0.
- The first command (P0 write to address 0) is on the memory port in cycle 1, with `busy`=1 from cycle 1.
- Command cycles run 1..6*SIZE: P0 takes SIZE, P1 takes 2*SIZE, P2 takes 2*SIZE, P3 takes SIZE.
- DRAIN compare happens in cycle 6*SIZE+1.
- From cycle 6*SIZE+2: `done`=1 and `busy`=0. `fail`, `fail_addr`, `fail_data` and `err_count` are final and stable.
- Back-to-back runs: `start` in the first DONE cycle begins a new test with the same cycle-1 timing.
- Every read is followed by exactly one compare; no compare is issued for a write.

## Test plan
- Fault-free memory, SIZE=16, BG=8'h55, `start` pulsed in cycle 0 → `busy` over cycles 1..97; `done`=1 and `busy`=0 at cycle 98; `fail`=0 and `err_count`=0; final memory contents all 8'h55.
- Memory model with bit 0 stuck-at-0 at address 5, SIZE=16 → `fail`=1, `fail_addr`=5, `fail_data`=8'h54, `err_count`=2 (mismatches in P1 and P3 only).
- Stuck-at-1 on bit 7 at every address, SIZE=16, ERR_W=4 → `fail_addr`=0, `fail_data`=8'hD5, `err_count` saturates at 15.
- Address trace for SIZE=4 → `mem_addr` sequence 0,1,2,3 | 0,0,1,1,2,2,3,3 | 3,3,2,2,1,1,0,0 | 0,1,2,3; `mem_we` pattern 1111 | 01×4 | 01×4 | 0000; no address outside 0..3.
- `rst` asserted in cycle 20 of a SIZE=16 run → all outputs 0 in cycle 21 with state IDLE; a `start` in cycle 22 runs to completion with `done` at cycle 22+98.
- `start` held high throughout a run, then pulsed again in the first DONE cycle → no restart mid-run; the second test begins the cycle after DONE is sampled, and `fail`/`err_count` are cleared for it.
